// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a latched SEQ_W-bit pattern out MSB-first, repeated with idle gaps.
// Optional macro SEQ_GEN_PARITY_EN appends an even-parity bit to every repetition.
module sequence_generator #(
  parameter int SEQ_W      = 4,
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SEQ_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

`ifdef SEQ_GEN_PARITY_EN
  localparam int REP_LEN = SEQ_W + 1;
`else
  localparam int REP_LEN = SEQ_W;
`endif
  localparam int IDX_W = $clog2(SEQ_W + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t           state_q, state_d;
  logic [SEQ_W-1:0] pat_q, pat_d;
  logic [SEQ_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             out_d, valid_d, busy_d, done_d;
  logic             load_rep;
`ifdef SEQ_GEN_PARITY_EN
  logic             par_q, par_d;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    pat_d    = pat_q;
    sh_d     = sh_q;
    rep_d    = rep_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    out_d    = 1'b0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    load_rep = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
    par_d    = par_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = SEND;
          pat_d   = pattern;
          sh_d    = pattern << 1;
          rep_d   = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
          idx_d   = '0;
          out_d   = pattern[SEQ_W-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
          par_d   = ^pattern;
`endif
        end
      end

      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (idx_q != IDX_W'(REP_LEN - 1)) begin
          idx_d   = idx_q + 1'b1;
          valid_d = 1'b1;
          busy_d  = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
          if (idx_q == IDX_W'(SEQ_W - 1)) begin
            out_d = par_q;
          end else begin
            out_d = sh_q[SEQ_W-1];
            sh_d  = sh_q << 1;
          end
`else
          out_d = sh_q[SEQ_W-1];
          sh_d  = sh_q << 1;
`endif
        end else if (rep_q > CNT_W'(1)) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = '0;
            busy_d  = 1'b1;
          end else begin
            load_rep = 1'b1;
          end
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          load_rep = 1'b1;
        end else begin
          gap_d  = gap_q + 1'b1;
          busy_d = 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Restart the latched pattern for the next repetition.
    if (load_rep) begin
      state_d = SEND;
      rep_d   = rep_q - 1'b1;
      idx_d   = '0;
      sh_d    = pat_q << 1;
      out_d   = pat_q[SEQ_W-1];
      valid_d = 1'b1;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    if (!reset) begin
      state_q    <= IDLE;
      pat_q      <= '0;
      sh_q       <= '0;
      rep_q      <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      pat_q      <= pat_d;
      sh_q       <= sh_d;
      rep_q      <= rep_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      data_out   <= out_d;
      data_valid <= valid_d;
      busy       <= busy_d;
      done       <= done_d;
`ifdef SEQ_GEN_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: randomized transmissions compared cycle by cycle
// against a queue of expected {valid, data, busy, done} tuples built from the transmission rules.
module tb_sequence_generator;
  localparam int SEQ_W      = 4;
  localparam int CNT_W      = 4;
  localparam int GAP_CYCLES = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [SEQ_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic             abort;
  logic             data_out, data_valid, busy, done;

  int total = 0;
  int bad   = 0;

  sequence_generator #(.SEQ_W(SEQ_W), .CNT_W(CNT_W), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .abort(abort), .data_out(data_out),
    .data_valid(data_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle outputs {valid, data, busy, done} from the cycle after start onward.
  function automatic void build(input logic [SEQ_W-1:0] pat, input int n_req,
                                output logic [3:0] q[$]);
    int n;
    q = {};
    n = (n_req == 0) ? 1 : n_req;
    for (int r = 0; r < n; r++) begin
      for (int b = SEQ_W - 1; b >= 0; b--) q.push_back({1'b1, pat[b], 1'b1, 1'b0});
`ifdef SEQ_GEN_PARITY_EN
      q.push_back({1'b1, ^pat, 1'b1, 1'b0});
`endif
      if (r < n - 1)
        for (int g = 0; g < GAP_CYCLES; g++) q.push_back(4'b0010);
    end
    q.push_back(4'b0001);
    q.push_back(4'b0000);
  endfunction

  task automatic check_out(input logic [3:0] exp, input string name, input int cyc);
    logic [3:0] got;
    got = {data_valid, data_out, busy, done};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: {valid,data,busy,done} got=%b want=%b", name, cyc, got, exp);
    end
  endtask

  // Runs one transmission; abort_at >= 0 raises abort while that expected cycle is showing.
  task automatic send(input logic [SEQ_W-1:0] pat, input int n_req, input bit noise,
                      input int abort_at, input string name);
    logic [3:0] q[$];
    build(pat, n_req, q);
    start = 1'b1; pattern = pat; repeat_cnt = CNT_W'(n_req); abort = 1'b0;
    tick();
    start = 1'b0;
    for (int j = 0; j < q.size(); j++) begin
      check_out(q[j], name, j + 1);
      if (abort_at == j) begin
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_out(4'b0000, {name, "_abort"}, j + 2);
        return;
      end
      if (noise && j <= q.size() - 2) begin
        start      = 1'($urandom);
        pattern    = SEQ_W'($urandom);
        repeat_cnt = CNT_W'($urandom);
      end else begin
        start = 1'b0;
      end
      if (j < q.size() - 1) tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; abort = 1'b0; pattern = 4'b1011; repeat_cnt = 4'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out(4'b0000, "reset_hold", i);
    end
    reset = 1'b1;
    send(4'b1011, 1, 1'b0, -1, "after_reset");
  endtask

  task automatic test_directed();
    send(4'b1011, 1, 1'b0, -1, "single_1011");
    send(4'b1011, 3, 1'b0, -1, "triple_1011");
    send(4'b0110, 0, 1'b0, -1, "rep_zero");
    send(4'b1001, 15, 1'b0, -1, "rep_max");
  endtask

  task automatic test_ignore_inputs();
    send(4'b1011, 1, 1'b1, -1, "ignore_single");
    send(4'b1100, 2, 1'b1, -1, "ignore_double");
  endtask

  task automatic test_abort();
    send(4'b1100, 2, 1'b0, 2, "abort_bit3");
    send(4'b0110, 1, 1'b0, -1, "after_abort");
    send(4'b1010, 3, 1'b0, SEQ_W, "abort_gap");
    // start together with abort in IDLE must be ignored
    start = 1'b1; abort = 1'b1; pattern = 4'b1111; repeat_cnt = 4'd1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_out(4'b0000, "start_with_abort", 1);
    tick();
    check_out(4'b0000, "start_with_abort_idle", 2);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; pattern = 4'b1111; repeat_cnt = 4'd3;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    check_out(4'b0000, "mid_reset", 1);
    reset = 1'b1;
    tick();
    check_out(4'b0000, "mid_reset_idle", 2);
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      logic [SEQ_W-1:0] p;
      int n, len, ab;
      p   = SEQ_W'($urandom);
      n   = $urandom_range(0, (1 << CNT_W) - 1);
      len = ((n == 0) ? 1 : n) * (SEQ_W + GAP_CYCLES);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - GAP_CYCLES - 1) : -1;
      send(p, n, 1'($urandom), ab, "random");
    end
  endtask

  task automatic test_back_to_back();
    send(4'b1110, 1, 1'b0, -1, "b2b_a");
    send(4'b0001, 2, 1'b0, -1, "b2b_b");
    send(4'b0101, 1, 1'b0, -1, "b2b_c");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_inputs();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
